// File: rtl/timer_pkg.sv
// Shared types and constants for the timer sequencing controller.
package timer_pkg;

  localparam int unsigned TIMER_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRELOAD = 3'd1,
    ST_RUN     = 3'd2,
    ST_RELOAD  = 3'd3,
    ST_DONE    = 3'd4
  } timer_state_t;

  localparam logic [1:0] MODE_FREE    = 2'b00;
  localparam logic [1:0] MODE_ONESHOT = 2'b01;
  localparam logic [1:0] MODE_RELOAD  = 2'b10;

endpackage

// File: rtl/timer_wrap_detect.sv
// Detects counter wrap (FF->00 up, 00->FF down) by comparing the previous
// and current counter values; an edge that follows a load is masked so a
// software/reload load cannot be mistaken for a wrap.
module timer_wrap_detect #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             counter_internal_clk,
  input  logic             counter_reset_n,
  input  logic             run_active,
  input  logic             dir,
  input  logic             ctrl_load,
  input  logic [WIDTH-1:0] counter_value,
  output logic             ovf_evt,
  output logic             udf_evt
);

  logic [WIDTH-1:0] last_value;
  logic             load_d;

  // Track previous counter value and whether the last edge was a load
  always_ff @(posedge counter_internal_clk or negedge counter_reset_n) begin
    if (!counter_reset_n) begin
      last_value <= '0;
      load_d     <= 1'b0;
    end else begin
      last_value <= counter_value;
      load_d     <= ctrl_load;
    end
  end

  // Wrap event decode, only meaningful while counting
  always_comb begin
    ovf_evt = run_active && !load_d && !dir &&
              (last_value == '1) && (counter_value == '0);
    udf_evt = run_active && !load_d && dir &&
              (last_value == '0) && (counter_value == '1);
  end

endmodule

// File: rtl/timer_mode_ctrl.sv
// Timer sequencing controller: turns TCR start/mode/direction into counter
// load/enable/direction controls, tracks wrap events, sticky flags and IRQ.
module timer_mode_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH     = TIMER_WIDTH,
  parameter int unsigned EVT_CNT_W = 4
) (
  input  logic                 counter_internal_clk,
  input  logic                 counter_reset_n,
  input  logic                 cfg_start,
  input  logic [1:0]           cfg_mode,
  input  logic                 cfg_up_down,
  input  logic [WIDTH-1:0]     cfg_tdr,
  input  logic                 sw_load,
  input  logic [1:0]           flag_clr,
  input  logic [1:0]           int_en,
  input  logic [WIDTH-1:0]     counter_value,
  output logic                 ctrl_load,
  output logic                 ctrl_enable,
  output logic                 ctrl_up_down,
  output logic [WIDTH-1:0]     ctrl_tdr,
  output logic                 ovf_flag,
  output logic                 udf_flag,
  output logic                 timer_irq,
  output logic [EVT_CNT_W-1:0] evt_count,
  output logic                 busy
);

  localparam logic [EVT_CNT_W-1:0] EVT_MAX = '1;

  timer_state_t state, state_nxt;
  logic         fsm_load;
  logic         ovf_evt, udf_evt, wrap_evt;
  logic         start_accept;

  timer_wrap_detect #(
    .WIDTH (WIDTH)
  ) u_wrap_detect (
    .counter_internal_clk (counter_internal_clk),
    .counter_reset_n      (counter_reset_n),
    .run_active           (state == ST_RUN),
    .dir                  (ctrl_up_down),
    .ctrl_load            (ctrl_load),
    .counter_value        (counter_value),
    .ovf_evt              (ovf_evt),
    .udf_evt              (udf_evt)
  );

  assign wrap_evt     = ovf_evt | udf_evt;
  assign start_accept = (state == ST_IDLE) && cfg_start;

  // State register
  always_ff @(posedge counter_internal_clk or negedge counter_reset_n) begin
    if (!counter_reset_n) state <= ST_IDLE;
    else                  state <= state_nxt;
  end

  // Next-state and Moore control decode; mode is sampled live at event time
  always_comb begin
    state_nxt   = state;
    fsm_load    = 1'b0;
    ctrl_enable = 1'b0;
    busy        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cfg_start) state_nxt = ST_PRELOAD;
      end
      ST_PRELOAD: begin
        fsm_load  = 1'b1;
        busy      = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        ctrl_enable = 1'b1;
        busy        = 1'b1;
        if (!cfg_start) begin
          state_nxt = ST_IDLE;
        end else if (wrap_evt) begin
          case (cfg_mode)
            MODE_ONESHOT: state_nxt = ST_DONE;
            MODE_RELOAD:  state_nxt = ST_RELOAD;
            default:      state_nxt = ST_RUN;
          endcase
        end
      end
      ST_RELOAD: begin
        fsm_load  = 1'b1;
        busy      = 1'b1;
        state_nxt = cfg_start ? ST_RUN : ST_IDLE;
      end
      ST_DONE: begin
        if (!cfg_start) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A reload load and a software load merge into a single load of cfg_tdr
  always_comb begin
    ctrl_load = fsm_load | sw_load;
    ctrl_tdr  = cfg_tdr;
    timer_irq = (ovf_flag & int_en[0]) | (udf_flag & int_en[1]);
  end

  // Direction latch, sticky flags (set beats clear) and saturating event count
  always_ff @(posedge counter_internal_clk or negedge counter_reset_n) begin
    if (!counter_reset_n) begin
      ctrl_up_down <= 1'b0;
      ovf_flag     <= 1'b0;
      udf_flag     <= 1'b0;
      evt_count    <= '0;
    end else begin
      if (start_accept) ctrl_up_down <= cfg_up_down;

      if (ovf_evt)          ovf_flag <= 1'b1;
      else if (flag_clr[0]) ovf_flag <= 1'b0;

      if (udf_evt)          udf_flag <= 1'b1;
      else if (flag_clr[1]) udf_flag <= 1'b0;

      if (start_accept)
        evt_count <= '0;
      else if (wrap_evt && (evt_count != EVT_MAX))
        evt_count <= evt_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_timer_mode_ctrl.sv
// Bench for timer_mode_ctrl: a behavioural counter closes the loop, and
// expected values are queued when stimulus is applied, then popped and
// compared against the DUT after the relevant clock edges.
module tb_timer_mode_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned EW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_start;
  logic [1:0]    cfg_mode;
  logic          cfg_up_down;
  logic [W-1:0]  cfg_tdr;
  logic          sw_load;
  logic [1:0]    flag_clr;
  logic [1:0]    int_en;
  logic [W-1:0]  cnt;
  logic          ctrl_load, ctrl_enable, ctrl_up_down;
  logic [W-1:0]  ctrl_tdr;
  logic          ovf_flag, udf_flag, timer_irq, busy;
  logic [EW-1:0] evt_count;

  timer_mode_ctrl #(
    .WIDTH     (W),
    .EVT_CNT_W (EW)
  ) dut (
    .counter_internal_clk (clk),
    .counter_reset_n      (rst_n),
    .cfg_start            (cfg_start),
    .cfg_mode             (cfg_mode),
    .cfg_up_down          (cfg_up_down),
    .cfg_tdr              (cfg_tdr),
    .sw_load              (sw_load),
    .flag_clr             (flag_clr),
    .int_en               (int_en),
    .counter_value        (cnt),
    .ctrl_load            (ctrl_load),
    .ctrl_enable          (ctrl_enable),
    .ctrl_up_down         (ctrl_up_down),
    .ctrl_tdr             (ctrl_tdr),
    .ovf_flag             (ovf_flag),
    .udf_flag             (udf_flag),
    .timer_irq            (timer_irq),
    .evt_count            (evt_count),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  // Behavioural 8-bit counter driven by the controller outputs
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (ctrl_load)   cnt <= ctrl_tdr;
    else if (ctrl_enable) cnt <= ctrl_up_down ? cnt - 8'd1 : cnt + 8'd1;
  end

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      check_val("sb_underflow", sb.size(), 1);
    end else begin
      e = sb.pop_front();
      check_val(e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int unsigned reloads;

  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; cfg_mode = 2'b00; cfg_up_down = 1'b0;
    cfg_tdr = '0; sw_load = 1'b0; flag_clr = 2'b00; int_en = 2'b00;

    // ---- reset state ----
    sb_push("rst_load", 0); sb_push("rst_en", 0); sb_push("rst_dir", 0);
    sb_push("rst_ovf", 0);  sb_push("rst_udf", 0); sb_push("rst_irq", 0);
    sb_push("rst_evt", 0);  sb_push("rst_busy", 0);
    tick(); tick();
    sb_pop(ctrl_load); sb_pop(ctrl_enable); sb_pop(ctrl_up_down);
    sb_pop(ovf_flag);  sb_pop(udf_flag);    sb_pop(timer_irq);
    sb_pop(evt_count); sb_pop(busy);
    rst_n = 1'b1;
    tick();

    // ---- up free-run from FD: overflow flagged, stays in RUN ----
    cfg_mode = 2'b00; cfg_up_down = 1'b0; cfg_tdr = 8'hFD; cfg_start = 1'b1;
    sb_push("t1_pre_load", 1); sb_push("t1_pre_busy", 1); sb_push("t1_pre_en", 0);
    tick();
    sb_pop(ctrl_load); sb_pop(busy); sb_pop(ctrl_enable);
    sb_push("t1_cnt_fd", 8'hFD); sb_push("t1_cnt_fe", 8'hFE);
    sb_push("t1_cnt_ff", 8'hFF); sb_push("t1_cnt_00", 8'h00);
    sb_push("t1_ovf_not_yet", 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      sb_pop(cnt);
      if (i == 3) sb_pop(ovf_flag);
    end
    sb_push("t1_ovf", 1); sb_push("t1_evt", 1); sb_push("t1_run_en", 1);
    sb_push("t1_cnt_01", 8'h01);
    tick();
    sb_pop(ovf_flag); sb_pop(evt_count); sb_pop(ctrl_enable); sb_pop(cnt);
    cfg_start = 1'b0;
    sb_push("t1_stop_en", 0); sb_push("t1_stop_busy", 0); sb_push("t1_sticky", 1);
    tick();
    sb_pop(ctrl_enable); sb_pop(busy); sb_pop(ovf_flag);
    flag_clr = 2'b01;
    sb_push("t1_clr_ovf", 0);
    tick();
    flag_clr = 2'b00;
    sb_pop(ovf_flag);

    // ---- down one-shot from 02: underflow -> DONE, irq, no auto-restart ----
    cfg_mode = 2'b01; cfg_up_down = 1'b1; cfg_tdr = 8'h02; int_en = 2'b10;
    cfg_start = 1'b1;
    sb_push("t2_evt_clr", 0); sb_push("t2_dir", 1);
    tick();
    sb_pop(evt_count); sb_pop(ctrl_up_down);
    sb_push("t2_cnt_02", 8'h02); sb_push("t2_cnt_01", 8'h01);
    sb_push("t2_cnt_00", 8'h00); sb_push("t2_cnt_ff", 8'hFF);
    sb_push("t2_udf_not_yet", 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      sb_pop(cnt);
      if (i == 3) sb_pop(udf_flag);
    end
    sb_push("t2_udf", 1); sb_push("t2_done_en", 0); sb_push("t2_done_busy", 0);
    sb_push("t2_irq", 1); sb_push("t2_evt", 1);     sb_push("t2_cnt_fe", 8'hFE);
    tick();
    sb_pop(udf_flag); sb_pop(ctrl_enable); sb_pop(busy);
    sb_pop(timer_irq); sb_pop(evt_count); sb_pop(cnt);
    for (int i = 0; i < 4; i++) begin
      sb_push("t2_hold_busy", 0); sb_push("t2_hold_load", 0);
      tick();
      sb_pop(busy); sb_pop(ctrl_load);
    end
    cfg_start = 1'b0;
    tick();
    flag_clr = 2'b10;
    sb_push("t2_clr_udf", 0); sb_push("t2_clr_irq", 0);
    tick();
    flag_clr = 2'b00;
    sb_pop(udf_flag); sb_pop(timer_irq);

    // ---- spurious-wrap guard: sw_load of 00 while at FF ----
    cfg_mode = 2'b00; cfg_up_down = 1'b0; cfg_tdr = 8'hFD; int_en = 2'b00;
    cfg_start = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    sb_push("t4_cnt_ff", 8'hFF);
    sb_pop(cnt);
    sw_load = 1'b1; cfg_tdr = 8'h00;
    sb_push("t4_sw_load_pass", 1);
    #1;
    sb_pop(ctrl_load);
    tick();
    sw_load = 1'b0;
    sb_push("t4_cnt_loaded", 8'h00);
    sb_pop(cnt);
    sb_push("t4_no_ovf", 0); sb_push("t4_evt0", 0); sb_push("t4_cnt_01", 8'h01);
    tick();
    sb_pop(ovf_flag); sb_pop(evt_count); sb_pop(cnt);

    // ---- clear coincident with ovf event: set wins; later clear works ----
    cfg_start = 1'b0;
    tick();
    cfg_tdr = 8'hFD; int_en = 2'b01; cfg_start = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    sb_push("t5_cnt_00", 8'h00); sb_push("t5_ovf_pre", 0);
    sb_pop(cnt); sb_pop(ovf_flag);
    flag_clr = 2'b01;
    sb_push("t5_set_wins", 1); sb_push("t5_irq_on", 1);
    tick();
    flag_clr = 2'b00;
    sb_pop(ovf_flag); sb_pop(timer_irq);
    flag_clr = 2'b01;
    sb_push("t5_late_clr", 0); sb_push("t5_irq_off", 0);
    tick();
    flag_clr = 2'b00;
    sb_pop(ovf_flag); sb_pop(timer_irq);
    cfg_start = 1'b0;
    tick();

    // ---- auto-reload up from FE: reload cycle, count saturation ----
    cfg_mode = 2'b10; cfg_up_down = 1'b0; cfg_tdr = 8'hFE; int_en = 2'b01;
    cfg_start = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    sb_push("t3_rl_load", 1); sb_push("t3_rl_en", 0); sb_push("t3_rl_busy", 1);
    sb_push("t3_evt1", 1);
    tick();
    sb_pop(ctrl_load); sb_pop(ctrl_enable); sb_pop(busy); sb_pop(evt_count);
    sb_push("t3_reloaded_fe", 8'hFE); sb_push("t3_run_en", 1);
    tick();
    sb_pop(cnt); sb_pop(ctrl_enable);
    reloads = 0;
    for (int i = 0; i < 79; i++) begin
      tick();
      if (ctrl_load && !ctrl_enable && busy) reloads++;
    end
    sb_push("t3_reloads", 20); sb_push("t3_evt_sat", 15);
    sb_push("t3_in_reload", 1); sb_push("t3_irq", 1);
    sb_pop(reloads); sb_pop(evt_count); sb_pop(ctrl_load); sb_pop(timer_irq);

    // ---- async reset in RELOAD, then restart ----
    rst_n = 1'b0;
    sb_push("t6_busy", 0); sb_push("t6_load", 0); sb_push("t6_en", 0);
    sb_push("t6_ovf", 0);  sb_push("t6_evt", 0);  sb_push("t6_irq", 0);
    #1;
    sb_pop(busy); sb_pop(ctrl_load); sb_pop(ctrl_enable);
    sb_pop(ovf_flag); sb_pop(evt_count); sb_pop(timer_irq);
    #2;
    rst_n = 1'b1;
    sb_push("t6_pre_load", 1); sb_push("t6_pre_busy", 1);
    tick();
    sb_pop(ctrl_load); sb_pop(busy);
    sb_push("t6_cnt_fe", 8'hFE); sb_push("t6_run_en", 1);
    tick();
    sb_pop(cnt); sb_pop(ctrl_enable);

    check_val("sb_leftover", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_mode_ctrl.md
Name: timer_mode_ctrl

Overview:
Sequencing controller for the 8-bit timer counter. Converts TCR-level configuration (start, mode, direction) into the counter's load/enable/up_down controls. Detects overflow and underflow wrap events, raises sticky flags and an interrupt, and implements free-run, one-shot and auto-reload modes. Sits between the register file (TCR/TDR/TSR/TIER) and the counter, in the counter_internal_clk domain.

Parameters:
WIDTH, 8, counter/TDR data width
EVT_CNT_W, 4, width of the saturating wrap-event counter

Ports:
counter_internal_clk  in  1  block clock (same edge as counter update)
counter_reset_n  in  1  asynchronous, active-low reset
cfg_start  in  1  TCR start level; 1=run request
cfg_mode  in  2  00 free-run, 01 one-shot, 10 auto-reload, 11 reserved (treated as free-run)
cfg_up_down  in  1  0=up, 1=down; latched at start
cfg_tdr  in  WIDTH  reload/preload value
sw_load  in  1  single-cycle software load strobe
flag_clr  in  2  W1C pulse: [0] ovf, [1] udf
int_en  in  2  interrupt enables: [0] ovf, [1] udf
counter_value  in  WIDTH  live counter value
ctrl_load  out  1  counter load request
ctrl_enable  out  1  counter count enable
ctrl_up_down  out  1  latched direction
ctrl_tdr  out  WIDTH  value to load
ovf_flag  out  1  sticky overflow flag
udf_flag  out  1  sticky underflow flag
timer_irq  out  1  (ovf_flag&int_en[0])|(udf_flag&int_en[1])
evt_count  out  EVT_CNT_W  saturating wrap-event count since start
busy  out  1  1 in PRELOAD/RUN/RELOAD

Behaviour:
- Reset (async): state=IDLE; all outputs 0; last_value=0, load_d=0.
- States: IDLE, PRELOAD, RUN, RELOAD, DONE; registered state, Moore decode.
- IDLE: cfg_start=1 sampled -> PRELOAD; latch dir=cfg_up_down; clear evt_count.
- PRELOAD: ctrl_load=1 for exactly one cycle -> RUN. Counter holds cfg_tdr one edge after PRELOAD.
- RUN: ctrl_enable=1. cfg_start=0 -> IDLE (ctrl_enable low from next cycle).
- Wrap detect (sub-module): last_value<=counter_value every edge; load_d<=ctrl_load.
- ovf_evt = state==RUN & !load_d & dir==0 & last_value==all-ones & counter_value==0.
- udf_evt = state==RUN & !load_d & dir==1 & last_value==0 & counter_value==all-ones.
- On evt in RUN: free-run stays RUN; one-shot -> DONE; auto-reload -> RELOAD.
- RELOAD: ctrl_load=1, ctrl_enable=0 for one cycle -> RUN. cfg_start=0 in RELOAD -> IDLE.
- DONE: enable=0, load=0. Stays until cfg_start=0 -> IDLE; restart requires start low then high.
- ctrl_load = (state==PRELOAD | state==RELOAD | sw_load); sw_load is combinational pass-through, any state.
- ctrl_tdr = cfg_tdr, combinational.
- Flags: set on evt the edge after detection. flag_clr clears. Set and clear on the same cycle: set wins.
- evt_count: +1 per evt, saturates at 2^EVT_CNT_W-1, cleared on IDLE->PRELOAD.
- sw_load coincident with evt: evt still flagged and counted; state follows mode. A RELOAD load and sw_load merge into one load of cfg_tdr.
- cfg_up_down/cfg_mode changes while busy: direction ignored until restart; mode sampled live at event time.
- Reset mid-operation: immediate IDLE, outputs 0, flags cleared.

Decomposition:
- Package timer_pkg: state enum encoding (IDLE=0..DONE=4), mode constants MODE_FREE/MODE_ONESHOT/MODE_RELOAD, WIDTH default.
- One sub-module: timer_wrap_detect (last_value/load_d registers, ovf_evt/udf_evt outputs). Instantiated once.

Test Plan:
- Up free-run, tdr=8'hFD, start=1: PRELOAD load pulse; values FD,FE,FF,00; ovf_flag=1 one edge after 00; state stays RUN; evt_count=1.
- Down one-shot, tdr=8'h02: values 02,01,00,FF -> udf_flag=1, state DONE, ctrl_enable=0. With int_en=2'b10, timer_irq=1. Start held high gives no restart.
- Auto-reload up, tdr=8'hFE: FE,FF,00 -> RELOAD one-cycle load -> FE, repeats. After 20 wraps with EVT_CNT_W=4, evt_count saturates at 15.
- Spurious-wrap guard: in RUN up, counter at FF, sw_load with tdr=8'h00. No ovf_flag, since load_d masks it.
- Flag_clr[0] pulse on the same cycle as a new ovf_evt: ovf_flag remains 1. A clear on a later idle cycle gives ovf_flag=0 and timer_irq=0.
- Assert counter_reset_n=0 mid-RELOAD: all outputs 0 asynchronously, state IDLE. After release with start=1, a new PRELOAD occurs.
